// File: rtl/fft_seq_if.sv
`default_nettype none
// ============================================================================
// fft_seq_if : control/handshake bundle between fft_seq and its environment
// Revision   : 1.0
// ============================================================================
interface fft_seq_if;
  logic       start;
  logic       abort;
  logic       bf_valid;
  logic       bf_ready;
  logic [1:0] bf_op;
  logic [2:0] addr_a;
  logic [2:0] addr_b;
  logic [2:0] tw_idx;
  logic [1:0] stage;
  logic       wb_ack;
  logic       busy;
  logic       done;
  logic [2:0] state_o;

  modport master (
    input  start, abort, bf_ready, wb_ack,
    output bf_valid, bf_op, addr_a, addr_b, tw_idx, stage, busy, done, state_o
  );

  modport slave (
    output start, abort, bf_ready, wb_ack,
    input  bf_valid, bf_op, addr_a, addr_b, tw_idx, stage, busy, done, state_o
  );
endinterface
`default_nettype wire

// File: rtl/fft_seq.sv
`default_nettype none
// ============================================================================
// fft_seq  : 8-point radix-2 FFT op sequencer with outstanding-op throttling
// Option   : FFT_SEQ_BITREV_EN adds a bit-reversal swap pass before stage 0
// Revision : 1.0
// ============================================================================
module fft_seq #(
  parameter int MAX_OUT = 3
) (
  input  wire logic  clock,
  input  wire logic  reset,
  fft_seq_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SWAP  = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] stage_q, stage_d;
  logic [2:0] out_q, out_d;
`ifdef FFT_SEQ_BITREV_EN
  logic       swp_q, swp_d;
`endif

  logic       xfer;
  logic       ack_eff;
  logic       can_issue;
  logic       drain_empty;
  logic       issuing;

  logic [1:0] op_code;
  logic [2:0] a_w, b_w, tw_w;

`ifdef FFT_SEQ_BITREV_EN
  assign issuing = (state_q == S_ISSUE) || (state_q == S_SWAP);
`else
  assign issuing = (state_q == S_ISSUE);
`endif

  assign can_issue   = (out_q < 3'(MAX_OUT));
  assign bus.bf_valid = issuing && can_issue;
  assign xfer        = bus.bf_valid && bus.bf_ready;
  // Acks with nothing outstanding are spurious and must not underflow.
  assign ack_eff     = bus.wb_ack && (out_q != 3'd0);
  assign drain_empty = (out_q == 3'd0) || ((out_q == 3'd1) && bus.wb_ack);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      stage_q <= 2'd0;
      out_q   <= 3'd0;
`ifdef FFT_SEQ_BITREV_EN
      swp_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      stage_q <= stage_d;
      out_q   <= out_d;
`ifdef FFT_SEQ_BITREV_EN
      swp_q   <= swp_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    stage_d = stage_q;
    out_d   = out_q;
`ifdef FFT_SEQ_BITREV_EN
    swp_d   = swp_q;
`endif

    case ({xfer, ack_eff})
      2'b10:   out_d = out_q + 3'd1;
      2'b01:   out_d = out_q - 3'd1;
      default: out_d = out_q;
    endcase

    if (bus.abort) begin
      state_d = S_IDLE;
      op_d    = 2'd0;
      stage_d = 2'd0;
      out_d   = 3'd0;
`ifdef FFT_SEQ_BITREV_EN
      swp_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_d    = 2'd0;
            stage_d = 2'd0;
`ifdef FFT_SEQ_BITREV_EN
            state_d = S_SWAP;
`else
            state_d = S_ISSUE;
`endif
          end
        end
`ifdef FFT_SEQ_BITREV_EN
        S_SWAP: begin
          if (xfer) begin
            if (op_q == 2'd1) begin
              state_d = S_DRAIN;
              op_d    = 2'd0;
              swp_d   = 1'b1;
            end else begin
              op_d = op_q + 2'd1;
            end
          end
        end
`endif
        S_ISSUE: begin
          if (xfer) begin
            if (op_q == 2'd3) begin
              state_d = S_DRAIN;
              op_d    = 2'd0;
            end else begin
              op_d = op_q + 2'd1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_empty) begin
`ifdef FFT_SEQ_BITREV_EN
            // The swap pass drains into stage 0 without bumping the stage.
            if (swp_q) begin
              swp_d   = 1'b0;
              state_d = S_ISSUE;
            end else
`endif
            if (stage_q == 2'd2) begin
              state_d = S_DONE;
            end else begin
              stage_d = stage_q + 2'd1;
              state_d = S_ISSUE;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          stage_d = 2'd0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Op fields are forced to zero outside the issuing states.
  always_comb begin
    op_code = 2'b00;
    a_w     = 3'd0;
    b_w     = 3'd0;
    tw_w    = 3'd0;
    case (state_q)
`ifdef FFT_SEQ_BITREV_EN
      S_SWAP: begin
        op_code = 2'b01;
        a_w     = op_q[0] ? 3'd3 : 3'd1;
        b_w     = op_q[0] ? 3'd6 : 3'd4;
      end
`endif
      S_ISSUE: begin
        case (stage_q)
          2'd0: begin
            a_w = {op_q, 1'b0};
            b_w = {op_q, 1'b1};
          end
          2'd1: begin
            a_w  = {op_q[1], 1'b0, op_q[0]};
            b_w  = {op_q[1], 1'b1, op_q[0]};
            tw_w = {1'b0, op_q[0], 1'b0};
          end
          2'd2: begin
            a_w  = {1'b0, op_q};
            b_w  = {1'b1, op_q};
            tw_w = {1'b0, op_q};
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.bf_op   = op_code;
  assign bus.addr_a  = a_w;
  assign bus.addr_b  = b_w;
  assign bus.tw_idx  = tw_w;
  assign bus.stage   = stage_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE) && !bus.abort;
  assign bus.state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_seq.sv
`default_nettype none
// ============================================================================
// tb_fft_seq : self-checking bench for fft_seq (fixed vectors + random model)
// Revision   : 1.0
// ============================================================================
module tb_fft_seq;

  localparam int MAX_OUT = 3;

  typedef struct {
    int st;
    int a;
    int b;
    int tw;
  } vec_t;

  typedef struct {
    int op;
    int a;
    int b;
    int tw;
    int st;
  } op_t;

  logic clock;
  logic reset;
  fft_seq_if bus ();

  fft_seq #(.MAX_OUT(MAX_OUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl [12];
  op_t  exp_q [$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int pk(input int op, input int a, input int b, input int tw, input int st);
    return (op << 11) | (a << 8) | (b << 5) | (tw << 2) | st;
  endfunction

  function automatic int fields();
    return pk(int'(bus.bf_op), int'(bus.addr_a), int'(bus.addr_b), int'(bus.tw_idx), int'(bus.stage));
  endfunction

  function automatic int all_outs();
    return {13'd0, bus.bf_valid, bus.bf_op, bus.addr_a, bus.addr_b, bus.tw_idx,
            bus.stage, bus.busy, bus.done, bus.state_o};
  endfunction

  // Reference schedule derived directly from the span/pos arithmetic.
  task automatic fill_exp();
    op_t e;
    exp_q.delete();
`ifdef FFT_SEQ_BITREV_EN
    e = '{1, 1, 4, 0, 0}; exp_q.push_back(e);
    e = '{1, 3, 6, 0, 0}; exp_q.push_back(e);
`endif
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 4; k++) begin
        int span, pos;
        span = 1 << s;
        pos  = k % span;
        e.op = 0;
        e.a  = (k / span) * 2 * span + pos;
        e.b  = e.a + span;
        e.tw = pos * (1 << (2 - s));
        e.st = s;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    bus.start = 0; bus.abort = 0; bus.bf_ready = 0; bus.wb_ack = 0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_ordering();
    int  nx, done_cnt, done_at, n_exp, exp_done;
    bit  pend;
    nx = 0; done_cnt = 0; done_at = -1; pend = 0;
`ifdef FFT_SEQ_BITREV_EN
    n_exp = 14; exp_done = 19;
`else
    n_exp = 12; exp_done = 16;
`endif
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) tick();
      if (bus.done) begin done_cnt++; done_at = cyc; end
      bus.start    = (cyc == 0);
      bus.wb_ack   = pend;
      bus.bf_ready = 1'b1;
      pend = bus.bf_valid;
      if (bus.bf_valid) begin
`ifdef FFT_SEQ_BITREV_EN
        if (nx == 0)      chk("swap0", fields(), pk(1, 1, 4, 0, 0));
        else if (nx == 1) chk("swap1", fields(), pk(1, 3, 6, 0, 0));
        else if (nx < 14) chk($sformatf("order%0d", nx - 2), fields(),
                              pk(0, tbl[nx-2].a, tbl[nx-2].b, tbl[nx-2].tw, tbl[nx-2].st));
`else
        if (nx < 12) chk($sformatf("order%0d", nx), fields(),
                         pk(0, tbl[nx].a, tbl[nx].b, tbl[nx].tw, tbl[nx].st));
`endif
        nx++;
      end
    end
    chk("order_count", nx, n_exp);
    chk("done_pulses", done_cnt, 1);
    chk("done_cycle", done_at, exp_done);
    bus.wb_ack = 0;
  endtask

  task automatic test_throttle();
    bit pend;
    int n;
    pend = 0;
    bus.start = 1; bus.bf_ready = 1; bus.wb_ack = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.start = 0;
      if (bus.state_o == 3'd2) break;
      bus.wb_ack = pend;
      pend = bus.bf_valid;
    end
    chk("thr_reach_issue", int'(bus.state_o), 2);
    bus.wb_ack = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.bf_valid) n++;
      tick();
    end
    chk("thr_xfers", n, MAX_OUT);
    chk("thr_valid_low", int'(bus.bf_valid), 0);
    bus.wb_ack = 1;
    n = bus.bf_valid ? 1 : 0;
    tick();
    bus.wb_ack = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.bf_valid) n++;
      tick();
    end
    chk("thr_one_more", n, 1);
  endtask

  task automatic test_stall();
    bit pend, found;
    int f0;
    pend = 0; found = 0;
    bus.start = 1; bus.bf_ready = 1; bus.wb_ack = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      bus.start  = 0;
      bus.wb_ack = pend;
      if (bus.bf_valid && fields() == pk(0, 1, 3, 2, 1)) begin
        found = 1;
        bus.bf_ready = 0;
        pend = 0;
      end else begin
        pend = bus.bf_valid;
      end
    end
    chk("stall_found", int'(found), 1);
    f0 = pk(0, 1, 3, 2, 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_valid%0d", i), int'(bus.bf_valid), 1);
      chk($sformatf("stall_hold%0d", i), fields(), f0);
      if (i < 4) begin tick(); bus.wb_ack = 0; end
    end
    tick();
    bus.bf_ready = 1;
    chk("stall_offer", fields(), f0);
    tick();
    chk("stall_next", fields(), pk(0, 4, 6, 0, 1));
  endtask

  task automatic test_abort();
    bit pend;
    int dn;
    pend = 0; dn = 0;
    bus.start = 1; bus.bf_ready = 1; bus.wb_ack = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      bus.start  = 0;
      bus.wb_ack = pend;
      pend = bus.bf_valid;
      if (bus.state_o == 3'd2 && bus.stage == 2'd1) break;
    end
    chk("abort_in_stage1", int'(bus.stage), 1);
    bus.abort = 1;
    tick();
    bus.abort = 0; bus.wb_ack = 0;
    chk("abort_state", int'(bus.state_o), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_valid", int'(bus.bf_valid), 0);
    for (int i = 0; i < 4; i++) begin
      if (bus.done) dn++;
      tick();
    end
    chk("abort_no_done", dn, 0);
  endtask

  task automatic test_reset_drain();
    bit pend, seen;
    int dn;
    pend = 0; seen = 0; dn = 0;
    bus.start = 1; bus.bf_ready = 1; bus.wb_ack = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      bus.start = 0;
      if (bus.state_o == 3'd3) begin
        seen = 1;
        bus.wb_ack = 0;
      end else begin
        bus.wb_ack = pend;
        pend = bus.bf_valid;
      end
    end
    tick();
    chk("rst_in_drain", int'(bus.state_o), 3);
    reset = 1'b0;
    #1;
    chk("rst_async_outs", all_outs(), 0);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done) dn++;
    end
    chk("rst_no_done", dn, 0);
    chk("rst_stays_idle", int'(bus.state_o), 0);
  endtask

  task automatic run_random();
    op_t e;
    int  outst, last_phase, prev_f, ph, cyc;
    bit  fin, prev_stall, xf, ak;
    fill_exp();
    outst = 0; last_phase = -2; prev_f = 0; cyc = 0; fin = 0; prev_stall = 0;
    bus.start = 1; bus.abort = 0; bus.wb_ack = 0; bus.bf_ready = 1'($urandom_range(0, 1));
    while (!fin && cyc < 400) begin
      tick();
      cyc++;
      if (prev_stall) chk("rnd_stall_hold", fields(), prev_f);
      chk("rnd_busy", int'(bus.busy), 1);
      if (bus.bf_valid) chk("rnd_valid_limit", int'(outst < MAX_OUT), 1);
      if (bus.done) begin
        chk("rnd_done_left", exp_q.size(), 0);
        chk("rnd_done_outst", outst, 0);
        fin = 1;
      end
      bus.bf_ready = ($urandom_range(0, 3) != 0);
      ak = ($urandom_range(0, 2) == 0);
      bus.wb_ack = ak;
      bus.start  = fin ? 1'b0 : ($urandom_range(0, 7) == 0);
      xf = bus.bf_valid && bus.bf_ready;
      if (xf) begin
        if (exp_q.size() == 0) begin
          chk("rnd_extra_xfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_op", fields(), pk(e.op, e.a, e.b, e.tw, e.st));
          ph = (e.op == 1) ? -1 : e.st;
          if (ph != last_phase) chk("rnd_phase_drained", outst, 0);
          last_phase = ph;
        end
      end
      prev_stall = bus.bf_valid && !bus.bf_ready;
      prev_f     = fields();
      outst = outst + (xf ? 1 : 0) - ((ak && outst > 0) ? 1 : 0);
    end
    if (!fin) chk("rnd_timeout", 0, 1);
    bus.start = 0; bus.wb_ack = 0;
    tick();
    chk("rnd_idle_after", int'(bus.state_o), 0);
    chk("rnd_done_once", int'(bus.done), 0);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 1, 0}; tbl[1]  = '{0, 2, 3, 0};
    tbl[2]  = '{0, 4, 5, 0}; tbl[3]  = '{0, 6, 7, 0};
    tbl[4]  = '{1, 0, 2, 0}; tbl[5]  = '{1, 1, 3, 2};
    tbl[6]  = '{1, 4, 6, 0}; tbl[7]  = '{1, 5, 7, 2};
    tbl[8]  = '{2, 0, 4, 0}; tbl[9]  = '{2, 1, 5, 1};
    tbl[10] = '{2, 2, 6, 2}; tbl[11] = '{2, 3, 7, 3};

    bus.start = 0; bus.abort = 0; bus.bf_ready = 0; bus.wb_ack = 0;
    reset = 1'b0;
    #3;
    chk("reset_outs", all_outs(), 0);
    @(posedge clock); #1;
    chk("reset_held_state", int'(bus.state_o), 0);
    chk("reset_held_valid", int'(bus.bf_valid), 0);
    #2;
    reset = 1'b1;
    tick();

    bus.abort = 1; bus.start = 1;
    tick();
    bus.abort = 0; bus.start = 0;
    chk("idle_abort_priority", int'(bus.state_o), 0);

    test_ordering();
    do_reset();
    test_throttle();
    do_reset();
    test_stall();
    do_reset();
    test_abort();
    run_random();
    do_reset();
    test_reset_drain();
    for (int t = 0; t < 15; t++) run_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fft_seq.md
FFT_SEQ -- requirements
Module: fft_seq

Interface
REQ-001 SHALL have parameter: MAX_OUT, default 3, maximum butterfly ops issued but not yet acknowledged (1..7).
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  begin one 8-point transform; sampled only in IDLE.
REQ-005 SHALL have port: abort  input  1  synchronous cancel of a transform in progress.
REQ-006 SHALL have port: bf_valid  output  1  an op is offered to the butterfly datapath.
REQ-007 SHALL have port: bf_ready  input  1  the datapath accepts the offered op.
REQ-008 SHALL have port: bf_op  output  2  op code: 00 butterfly, 01 swap.
REQ-009 SHALL have ports: addr_a, addr_b  output  3 each  sample indices of the op.
REQ-010 SHALL have port: tw_idx  output  3  twiddle index 0..7 (W^tw_idx).
REQ-011 SHALL have port: stage  output  2  current radix-2 stage 0..2.
REQ-012 SHALL have port: wb_ack  input  1  one op's results have been written back.
REQ-013 SHALL have ports: busy  output  1, and done  output  1 (one-cycle completion pulse).
REQ-014 SHALL have port: state_o  output  3  state encoding for LED debug.

Function
REQ-015 SHALL implement states IDLE=0, SWAP=1, ISSUE=2, DRAIN=3, DONE=4, encoded on state_o.
REQ-016 SHALL, in IDLE, move on start=1 to SWAP when FFT_SEQ_BITREV_EN is defined, else to ISSUE at stage 0, op 0.
REQ-017 SHALL schedule butterfly k (0..3) of stage s as: span=2^s, pos=k mod span, addr_a=(k div span)*2*span+pos, addr_b=addr_a+span, tw_idx=pos*2^(2-s), bf_op=00.
REQ-018 SHALL treat a transfer as bf_valid and bf_ready both high on a rising edge; on transfer, advance to the next op.
REQ-019 SHALL hold bf_op, addr_a, addr_b, tw_idx and stage stable while bf_valid=1 and bf_ready=0.
REQ-020 SHALL assert bf_valid only in SWAP or ISSUE, and only when the outstanding count is below MAX_OUT.
REQ-021 SHALL increment the outstanding count on transfer, decrement it on wb_ack, and leave it unchanged when both occur in the same cycle.
REQ-022 SHALL ignore wb_ack while the outstanding count is 0.
REQ-023 SHALL enter DRAIN after the fourth transfer of a stage, or after the last swap transfer.
REQ-024 SHALL leave DRAIN when the outstanding count is 0, or is 1 with wb_ack=1, going to ISSUE at the next stage, or to DONE after stage 2.
REQ-025 SHALL spend exactly one cycle in DONE with done=1, then return to IDLE.
REQ-026 SHALL drive busy=1 in every state except IDLE, and ignore start while busy=1.
REQ-027 SHALL, on abort=1 in any non-IDLE state, go to IDLE at the next edge, clear the outstanding count, drop bf_valid and not pulse done; in IDLE, abort takes priority over start.

Reset
REQ-028 SHALL, while reset=0, hold state IDLE, outstanding count 0, op and stage counters 0, and drive bf_valid=0, bf_op=00, addr_a=addr_b=tw_idx=0, stage=0, busy=0, done=0, state_o=0.
REQ-029 SHALL, on reset asserted mid-transform, discard all progress with no done pulse; a new transform requires a fresh start.

Configuration
REQ-030 SHALL, when macro FFT_SEQ_BITREV_EN is defined, run SWAP first, issuing bf_op=01, tw_idx=0 swaps (1,4) then (3,6) in that order, then DRAIN, then stage 0.
REQ-031 SHALL, without FFT_SEQ_BITREV_EN, omit the SWAP state's behaviour entirely (the input is pre-ordered) and never issue bf_op=01.

Verification
REQ-032 SHALL test no-macro ordering: bf_ready=1, wb_ack one cycle after each transfer, start pulse in cycle 0 -> ops (a,b,tw) in this order: (0,1,0)(2,3,0)(4,5,0)(6,7,0), (0,2,0)(1,3,2)(4,6,0)(5,7,2), (0,4,0)(1,5,1)(2,6,2)(3,7,3); done=1 in cycle 16 only.
REQ-033 SHALL test the macro: same stimulus with FFT_SEQ_BITREV_EN defined -> swaps (1,4),(3,6) with bf_op=01 before the 12 butterflies; done=1 in cycle 19 only.
REQ-034 SHALL test throttling: bf_ready=1, wb_ack=0 -> exactly 3 transfers, then bf_valid=0; one wb_ack pulse -> exactly one more transfer.
REQ-035 SHALL test stalling: bf_ready=0 for 5 cycles during op (1,3,2) -> bf_valid=1 and all fields unchanged for all 5 cycles, then one transfer.
REQ-036 SHALL test cancellation: abort=1 during stage 1 -> IDLE next cycle, busy=0, bf_valid=0, no done; a subsequent start restarts at op (0,1,0).
REQ-037 SHALL test reset: reset=0 mid-DRAIN -> all outputs take their reset values immediately, without a clock edge.
